// File: rtl/countdown_pkg.sv
// Shared types and default sizing for the countdown/decrement block.
package countdown_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_STEP  = 1;

endpackage

// File: rtl/decrementer.sv
// Combinational WIDTH-bit subtractor; borrow flags amount exceeding the operand.
module decrementer #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] amount,
  output logic [WIDTH-1:0] out,
  output logic             borrow
);

  assign out    = in - amount;
  assign borrow = (amount > in);

endmodule

// File: rtl/countdown_decrementer.sv
// Registered down-counter: single-step wrap decrement in IDLE, saturating
// STEP countdown in RUN, one-cycle done pulse on completion.
module countdown_decrementer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic             dec,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             borrow_nxt;
  logic [WIDTH-1:0] amount;
  logic [WIDTH-1:0] diff;
  logic             under;

  // RUN never wraps: any underflow clamps the count to zero.
  function automatic logic [WIDTH-1:0] sat_floor(input logic [WIDTH-1:0] d,
                                                 input logic             u);
    return u ? '0 : d;
  endfunction

  decrementer #(.WIDTH(WIDTH)) u_dec (
    .in     (out),
    .amount (amount),
    .out    (diff),
    .borrow (under)
  );

  always_comb begin
    state_nxt  = state;
    out_nxt    = out;
    borrow_nxt = 1'b0;
    amount     = (state == S_RUN) ? STEP_W : ONE_W;
    case (state)
      S_IDLE: begin
        if (start) begin
          out_nxt   = in;
          state_nxt = (in == '0) ? S_DONE : S_RUN;
        end else if (dec) begin
          out_nxt    = diff;
          borrow_nxt = under;
        end
      end
      S_RUN: begin
        if (en) begin
          out_nxt = sat_floor(diff, under);
          if (under || (diff == '0)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        out_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      out    <= '0;
      borrow <= 1'b0;
    end else begin
      state  <= state_nxt;
      out    <= out_nxt;
      borrow <= borrow_nxt;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_countdown_decrementer.sv
// Bench for countdown_decrementer: STEP=1 and STEP=3 builds driven in parallel
// and compared every cycle against an arithmetic reference model.
module tb_countdown_decrementer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       start = 1'b0, dec = 1'b0, en = 1'b0;

  logic [3:0] out1, out3;
  logic       busy1, done1, borrow1, busy3, done3, borrow3;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    int mode;  // 0 idle, 1 counting, 2 finished
    int val;
    bit brw;
  } mdl_t;

  mdl_t m1, m3;

  countdown_decrementer #(.WIDTH(4), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in(din), .start(start), .dec(dec), .en(en),
    .out(out1), .busy(busy1), .done(done1), .borrow(borrow1)
  );

  countdown_decrementer #(.WIDTH(4), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .in(din), .start(start), .dec(dec), .en(en),
    .out(out3), .busy(busy3), .done(done3), .borrow(borrow3)
  );

  always #5 clk = ~clk;

  function automatic mdl_t model_next(mdl_t m, int step, bit s, bit d, bit e, int v);
    mdl_t r = m;
    r.brw = 1'b0;
    case (m.mode)
      0: begin
        if (s) begin
          r.val  = v;
          r.mode = (v == 0) ? 2 : 1;
        end else if (d) begin
          r.brw = (m.val == 0);
          r.val = (m.val + 15) % 16;
        end
      end
      1: begin
        if (e) begin
          if (m.val <= (step % 16)) begin
            r.val  = 0;
            r.mode = 2;
          end else begin
            r.val = m.val - step;
          end
        end
      end
      default: begin
        r.mode = 0;
        r.val  = 0;
      end
    endcase
    return r;
  endfunction

  function automatic mdl_t model_reset();
    mdl_t r;
    r.mode = 0;
    r.val  = 0;
    r.brw  = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s1.out"},    32'(out1),    32'(m1.val));
    chk({tag, ".s1.busy"},   32'(busy1),   32'(m1.mode == 1));
    chk({tag, ".s1.done"},   32'(done1),   32'(m1.mode == 2));
    chk({tag, ".s1.borrow"}, 32'(borrow1), 32'(m1.brw));
    chk({tag, ".s3.out"},    32'(out3),    32'(m3.val));
    chk({tag, ".s3.busy"},   32'(busy3),   32'(m3.mode == 1));
    chk({tag, ".s3.done"},   32'(done3),   32'(m3.mode == 2));
    chk({tag, ".s3.borrow"}, 32'(borrow3), 32'(m3.brw));
  endtask

  task automatic cyc(input string tag, input bit s, input bit d, input bit e, input int v);
    start = s;
    dec   = d;
    en    = e;
    din   = 4'(v);
    @(posedge clk);
    m1 = model_next(m1, 1, s, d, e, v);
    m3 = model_next(m3, 3, s, d, e, v);
    #1;
    check_all(tag);
  endtask

  initial begin
    m1 = model_reset();
    m3 = model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Wrap: first dec from zero borrows, then 15 quiet steps, then borrow again.
    cyc("wrap0", 0, 1, 0, 0);
    chk("wrap0.out", 32'(out1), 32'hF);
    chk("wrap0.borrow", 32'(borrow1), 32'h1);
    for (int i = 0; i < 15; i++) cyc("wrapN", 0, 1, 0, 0);
    chk("wrap15.out", 32'(out1), 32'h0);
    cyc("wrap16", 0, 1, 0, 0);
    chk("wrap16.out", 32'(out1), 32'hF);
    chk("wrap16.borrow", 32'(borrow1), 32'h1);
    cyc("idle", 0, 0, 0, 0);
    chk("borrow.pulse", 32'(borrow1), 32'h0);

    // Countdown from 5 with enable held.
    cyc("cd.load", 1, 0, 1, 5);
    chk("cd.load.out", 32'(out1), 32'h5);
    for (int i = 0; i < 6; i++) cyc("cd.run", 0, 0, 1, 0);
    cyc("cd.idle", 0, 0, 1, 0);

    // Gated enable from 3.
    cyc("gate.load", 1, 0, 0, 3);
    cyc("gate.e1", 0, 0, 1, 0);
    cyc("gate.e0", 0, 0, 0, 0);
    cyc("gate.e1", 0, 0, 1, 0);
    cyc("gate.e0", 0, 0, 0, 0);
    cyc("gate.e1", 0, 0, 1, 0);
    chk("gate.done", 32'(done1), 32'h1);
    cyc("gate.idle", 0, 0, 0, 0);

    // Zero load, start+dec collision, start during RUN.
    cyc("zero.load", 1, 0, 0, 0);
    chk("zero.done", 32'(done1), 32'h1);
    chk("zero.busy", 32'(busy1), 32'h0);
    cyc("zero.idle", 0, 0, 0, 0);
    cyc("coll", 1, 1, 0, 7);
    chk("coll.out", 32'(out1), 32'h7);
    chk("coll.borrow", 32'(borrow1), 32'h0);
    cyc("run.start", 1, 0, 0, 2);
    cyc("run.start", 1, 1, 0, 12);
    for (int i = 0; i < 9; i++) cyc("run.drain", 0, 0, 1, 0);

    // Step-3 saturation from 7 (the STEP=3 instance is the target).
    cyc("s3.load", 1, 0, 1, 7);
    for (int i = 0; i < 8; i++) cyc("s3.run", 0, 0, 1, 0);

    // Mid-countdown asynchronous reset.
    cyc("mr.load", 1, 0, 1, 10);
    for (int i = 0; i < 3; i++) cyc("mr.run", 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    m1 = model_reset();
    m3 = model_reset();
    check_all("mr.async");
    @(posedge clk);
    #1;
    check_all("mr.hold");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) cyc("mr.after", 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        m1 = model_reset();
        m3 = model_reset();
        check_all("rand.rst");
        #1;
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
